// File: rtl/cpu_pkg.sv
// Shared CPU encodings: branch types and the branch-resolve FSM states.
package cpu_pkg;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'd0,
      BR_BNE  = 3'd1,
      BR_BLT  = 3'd2,
      BR_BGT  = 3'd3,
      BR_BGE  = 3'd4,
      BR_BLE  = 3'd5,
      BR_JAL  = 3'd6,
      BR_RSVD = 3'd7
   } brType_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } brState_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition decode from ALU compare flags.
import cpu_pkg::*;

module branch_cond_eval (
   input  logic [2:0] brType,
   input  logic       zeroFlag,
   input  logic       lessThanFlag,
   input  logic       greaterThanFlag,
   output logic       taken,
   output logic       err
);

   logic cond;

   always_comb begin
      cond = 1'b0;
      case (brType_e'(brType))
         BR_BEQ:  cond = zeroFlag;
         BR_BNE:  cond = ~zeroFlag;
         BR_BLT:  cond = lessThanFlag;
         BR_BGT:  cond = greaterThanFlag;
         BR_BGE:  cond = greaterThanFlag | zeroFlag;
         BR_BLE:  cond = lessThanFlag | zeroFlag;
         BR_JAL:  cond = 1'b1;
         default: cond = 1'b0;
      endcase
   end

   // lt and gt together cannot come from a real compare; never act on it
   assign err   = lessThanFlag & greaterThanFlag;
   assign taken = cond & ~err;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve: evaluates the condition, flushes younger ops, then holds a PC redirect until acked.
import cpu_pkg::*;

module branch_resolve_unit #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              brValid,
   output logic              brReady,
   input  logic [2:0]        brType,
   input  logic              zeroFlag,
   input  logic              lessThanFlag,
   input  logic              greaterThanFlag,
   input  logic [ADDR_W-1:0] pcCurrent,
   input  logic [ADDR_W-1:0] branchOffset,
   output logic              flushOut,
   output logic              redirectValid,
   output logic [ADDR_W-1:0] redirectPC,
   input  logic              redirectAck,
   output logic              errPulse,
   output logic [CNT_W-1:0]  takenCount
);

   brState_e                 state, nextState;
   logic [3:0]               flushCnt;
   logic                     condTaken, condErr;
   logic                     accept, takenAccept;
   logic signed [ADDR_W-1:0] offsetS;
   logic [ADDR_W-1:0]        targetPC;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   branch_cond_eval uCondEval (
      .brType          (brType),
      .zeroFlag        (zeroFlag),
      .lessThanFlag    (lessThanFlag),
      .greaterThanFlag (greaterThanFlag),
      .taken           (condTaken),
      .err             (condErr)
   );

   assign brReady     = rst_n & (state == ST_IDLE);
   assign accept      = brValid & brReady;
   assign takenAccept = accept & condTaken;

   // Two's-complement add wraps naturally modulo 2^ADDR_W
   assign offsetS  = branchOffset;
   assign targetPC = pcCurrent + $unsigned(offsetS);

   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE:     if (takenAccept) nextState = ST_FLUSH;
         ST_FLUSH:    if (flushCnt == 4'd0) nextState = ST_REDIRECT;
         ST_REDIRECT: if (redirectAck) nextState = ST_IDLE;
         default:     nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         flushCnt      <= 4'd0;
         flushOut      <= 1'b0;
         redirectValid <= 1'b0;
         redirectPC    <= '0;
         errPulse      <= 1'b0;
         takenCount    <= '0;
      end else begin
         state         <= nextState;
         flushOut      <= (nextState == ST_FLUSH);
         redirectValid <= (nextState == ST_REDIRECT);
         errPulse      <= accept & condErr;
         if (takenAccept) begin
            // Counts remaining flush edges; the edge that sees zero leaves FLUSH
            flushCnt   <= 4'(FLUSH_CYCLES - 1);
            redirectPC <= targetPC;
            takenCount <= satInc(takenCount);
         end else if (state == ST_FLUSH) begin
            flushCnt   <= flushCnt - 4'd1;
         end
      end
   end

endmodule
